// File: rtl/led_frame_parser_pkg.sv
// Shared definitions for the LED frame parser.
// Holds the default sync byte, default timeout and state encodings.
package led_frame_parser_pkg;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_ADDR,
        ST_DATA,
        ST_CHECK
    } state_t;

endpackage

// File: rtl/led_frame_parser_pulse_sync.sv
// Two-flop synchronizer with a registered rising-edge detect.
// The pulse is high for one clock, three edges after async_in rises.
module pulse_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 3'b000;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
            pulse  <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/led_frame_parser.sv
// Frames UART bytes into LED update packets and writes the back buffer.
// A verified checksum commits the frame; bad packets or stalls flag an error.
module led_frame_parser
    import led_frame_parser_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clock_12mhz,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_commit,
    output logic       frame_error,
    output logic       busy
);

    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    state_t state, state_n;
    logic          strobe;
    logic          timeout;
    logic [GW-1:0] gap;
    logic [7:0]    count, count_n;
    logic [7:0]    start, start_n;
    logic [7:0]    idx, idx_n;
    logic [7:0]    acc, acc_n;
    logic          wr_en_n, commit_n, error_n;
    logic [7:0]    wr_addr_n, wr_data_n;

    pulse_sync u_rx_sync (
        .clk      (clock_12mhz),
        .reset    (reset),
        .async_in (rx_data_ready),
        .pulse    (strobe)
    );

    assign busy    = (state != ST_IDLE);
    assign timeout = busy && (gap == GW'(TIMEOUT_CYCLES - 1));

    // Gap counter: any strobe restarts it, so a strobe beats the timeout.
    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            gap <= '0;
        end else if (strobe || !busy) begin
            gap <= '0;
        end else begin
            gap <= gap + 1'b1;
        end
    end

    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            count        <= 8'h00;
            start        <= 8'h00;
            idx          <= 8'h00;
            acc          <= 8'h00;
            wr_en        <= 1'b0;
            wr_addr      <= 8'h00;
            wr_data      <= 8'h00;
            frame_commit <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            start        <= start_n;
            idx          <= idx_n;
            acc          <= acc_n;
            wr_en        <= wr_en_n;
            wr_addr      <= wr_addr_n;
            wr_data      <= wr_data_n;
            frame_commit <= commit_n;
            frame_error  <= error_n;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        start_n   = start;
        idx_n     = idx;
        acc_n     = acc;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        commit_n  = 1'b0;
        error_n   = 1'b0;
        if (strobe) begin
            unique case (state)
                ST_IDLE: begin
                    if (rx_data == SYNC_BYTE) state_n = ST_COUNT;
                end
                ST_COUNT: begin
                    if (rx_data == 8'h00) begin
                        error_n = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        count_n = rx_data;
                        acc_n   = rx_data;
                        state_n = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    start_n = rx_data;
                    acc_n   = acc ^ rx_data;
                    idx_n   = 8'h00;
                    state_n = ST_DATA;
                end
                ST_DATA: begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = start + idx;
                    wr_data_n = rx_data;
                    acc_n     = acc ^ rx_data;
                    idx_n     = idx + 8'h01;
                    if (idx == count - 8'h01) state_n = ST_CHECK;
                end
                ST_CHECK: begin
                    commit_n = (rx_data == acc);
                    error_n  = (rx_data != acc);
                    state_n  = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (timeout) begin
            error_n = 1'b1;
            state_n = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_led_frame_parser.sv
// Randomized and directed bench for led_frame_parser.
// A packet-level queue model predicts writes, commits and errors.
module tb_led_frame_parser;

    logic       clock_12mhz = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_commit;
    logic       frame_error;
    logic       busy;

    led_frame_parser dut (
        .clock_12mhz   (clock_12mhz),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_commit  (frame_commit),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #5 clock_12mhz = ~clock_12mhz;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    int checks = 0;
    int failures = 0;
    int n_commit = 0;
    int n_error = 0;
    wr_t exp_wr[$];
    int exp_ev[$];
    logic [7:0] pkt[$];
    wr_t log_wr[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet model: bytes since the sync marker are kept in a queue.
    function automatic void model_byte(input logic [7:0] b);
        int n;
        logic [7:0] x;
        wr_t w;
        if (pkt.size() == 0) begin
            if (b == 8'hA5) pkt.push_back(b);
            return;
        end
        pkt.push_back(b);
        n = pkt.size();
        if (n == 2 && b == 8'h00) begin
            exp_ev.push_back(1);
            pkt.delete();
            return;
        end
        if (n >= 4 && n <= 3 + int'(pkt[1])) begin
            w.a = 8'(int'(pkt[2]) + n - 4);
            w.d = b;
            exp_wr.push_back(w);
        end
        if (n == int'(pkt[1]) + 4) begin
            x = 8'h00;
            for (int i = 1; i <= n - 2; i++) x ^= pkt[i];
            exp_ev.push_back((x == b) ? 0 : 1);
            pkt.delete();
        end
    endfunction

    always @(negedge clock_12mhz) begin
        if (!reset) begin
            if (wr_en) begin
                wr_t w;
                w.a = wr_addr;
                w.d = wr_data;
                log_wr.push_back(w);
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexp_wr: got %02h<-%02h expected none",
                             wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", wr_addr, e.a);
                    chk("wr_data", wr_data, e.d);
                end
            end
            if (frame_commit) n_commit++;
            if (frame_error) n_error++;
            chk("pulse_excl", int'(frame_commit & frame_error), 0);
            if (frame_commit || frame_error) begin
                if (exp_ev.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexp_result: got c=%0b e=%0b expected none",
                             frame_commit, frame_error);
                end else begin
                    chk("result_kind", int'(frame_error), exp_ev.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int lat);
        @(negedge clock_12mhz);
        rx_data = b;
        rx_data_ready = 1'b1;
        model_byte(b);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock_12mhz);
            #1;
            if (lat == 0 && (wr_en || frame_commit || frame_error)) lat = k;
            if (k == 3) rx_data_ready = 1'b0;
        end
        chk("drain_wr", exp_wr.size(), 0);
        chk("drain_ev", exp_ev.size(), 0);
        chk("busy", int'(busy), int'(pkt.size() != 0));
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        int lat;
        foreach (q[i]) send_byte(q[i], lat);
    endtask

    task automatic do_reset();
        @(negedge clock_12mhz);
        reset = 1'b1;
        rx_data_ready = 1'b0;
        repeat (2) @(negedge clock_12mhz);
        chk("rst_out", int'({wr_en, frame_commit, frame_error, busy}), 0);
        chk("rst_addr", int'(wr_addr), 0);
        chk("rst_data", int'(wr_data), 0);
        pkt.delete();
        exp_wr.delete();
        exp_ev.delete();
        @(negedge clock_12mhz);
        reset = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int c0, e0;
        logic [7:0] q[$];
        reset = 1'b1;
        rx_data = 8'h00;
        rx_data_ready = 1'b0;
        repeat (3) @(negedge clock_12mhz);
        do_reset();

        // Good packet with latency pinning on one data byte and CHK.
        log_wr.delete();
        c0 = n_commit;
        e0 = n_error;
        send_seq('{8'hA5, 8'h03, 8'h10});
        send_byte(8'h11, lat);
        chk("lat_data", lat, 4);
        send_seq('{8'h22, 8'h33});
        send_byte(8'h13, lat);
        chk("lat_chk", lat, 4);
        chk("a_nwr", log_wr.size(), 3);
        if (log_wr.size() == 3) begin
            chk("a_w0", int'({log_wr[0].a, log_wr[0].d}), 16'h1011);
            chk("a_w1", int'({log_wr[1].a, log_wr[1].d}), 16'h1122);
            chk("a_w2", int'({log_wr[2].a, log_wr[2].d}), 16'h1233);
        end
        chk("a_commit", n_commit - c0, 1);
        chk("a_error", n_error - e0, 0);

        // Same packet, wrong checksum.
        log_wr.delete();
        c0 = n_commit;
        e0 = n_error;
        send_seq('{8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h14});
        chk("b_nwr", log_wr.size(), 3);
        chk("b_commit", n_commit - c0, 0);
        chk("b_error", n_error - e0, 1);

        // Address wrap.
        log_wr.delete();
        c0 = n_commit;
        send_seq('{8'hA5, 8'h02, 8'hFF, 8'hAA, 8'hBB, 8'hEC});
        chk("w_nwr", log_wr.size(), 2);
        if (log_wr.size() == 2) begin
            chk("w_w0", int'({log_wr[0].a, log_wr[0].d}), 16'hFFAA);
            chk("w_w1", int'({log_wr[1].a, log_wr[1].d}), 16'h00BB);
        end
        chk("w_commit", n_commit - c0, 1);

        // Noise then a zero count.
        log_wr.delete();
        e0 = n_error;
        send_seq('{8'h00, 8'h7E});
        chk("noise_busy", int'(busy), 0);
        send_seq('{8'hA5, 8'h00});
        chk("z_error", n_error - e0, 1);
        chk("z_nwr", log_wr.size(), 0);

        // Stall inside a packet.
        e0 = n_error;
        send_seq('{8'hA5, 8'h03, 8'h10});
        repeat (4000) @(negedge clock_12mhz);
        chk("to_early_busy", int'(busy), 1);
        chk("to_early_err", n_error - e0, 0);
        exp_ev.push_back(1);
        pkt.delete();
        repeat (200) @(negedge clock_12mhz);
        chk("to_error", n_error - e0, 1);
        chk("to_busy", int'(busy), 0);
        c0 = n_commit;
        send_seq('{8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h13});
        chk("to_recover", n_commit - c0, 1);

        // Reset in the middle of a packet.
        c0 = n_commit;
        send_seq('{8'hA5, 8'h03, 8'h10, 8'h11});
        do_reset();
        chk("mid_commit", n_commit - c0, 0);
        send_seq('{8'hA5, 8'h02, 8'hFF, 8'hAA, 8'hBB, 8'hEC});
        chk("mid_recover", n_commit - c0, 1);

        // Random traffic: noise, zero counts, good and corrupted packets.
        for (int p = 0; p < 40; p++) begin
            int cnt;
            logic [7:0] x;
            q.delete();
            if ($urandom_range(0, 3) == 0) q.push_back(8'($urandom_range(0, 255)));
            q.push_back(8'hA5);
            if ($urandom_range(0, 9) == 0) begin
                q.push_back(8'h00);
            end else begin
                cnt = $urandom_range(1, 20);
                q.push_back(8'(cnt));
                q.push_back(8'($urandom_range(0, 255)));
                x = 8'(cnt) ^ q[q.size() - 1];
                for (int i = 0; i < cnt; i++) begin
                    q.push_back(($urandom_range(0, 7) == 0) ? 8'hA5
                                : 8'($urandom_range(0, 255)));
                    x ^= q[q.size() - 1];
                end
                if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
                q.push_back(x);
            end
            send_seq(q);
        end

        repeat (10) @(negedge clock_12mhz);
        chk("end_wr", exp_wr.size(), 0);
        chk("end_ev", exp_ev.size(), 0);
        chk("end_busy", int'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
